// File: rtl/sync_split8_retire_pkg.sv
// Shared constants, FSM state type and destination-field helper for the
// clocked 1-to-8 retire dispatcher.
package sync_split8_retire_pkg;

    localparam int unsigned NCH    = 8;
    localparam int unsigned DEST_W = 3;
    localparam int unsigned MAX_DW = 64;

    typedef enum logic {
        IDLE     = 1'b0,
        DISPATCH = 1'b1
    } state_e;

    // The destination is the top DEST_W bits of a dw-bit token.
    function automatic logic [DEST_W-1:0] get_dest(input logic [MAX_DW-1:0] data,
                                                   input int unsigned       dw);
        return DEST_W'(data >> (dw - DEST_W));
    endfunction

endpackage

// File: rtl/sync_split8_retire_toggle_sync.sv
// Synchroniser plus transition detector for one 2-phase handshake wire.
// ev_o is high for exactly one clk cycle per transition of tog_i.
module toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic tog_i,
    output logic ev_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the asynchronous level through the synchroniser and keep the last settled value.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses <= so every flop samples its pre-edge inputs.
        if (!rstn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tog_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign ev_o = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/sync_split8_retire.sv
// Clocked 1-to-8 dispatcher: takes a 2-phase drive/free token stream, buffers
// one token and forwards it on the 2-phase channel named by its dest field.
module sync_split8_retire
    import sync_split8_retire_pkg::*;
#(
    parameter int DATA_WIDTH  = 12,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_drive,
    input  logic [DATA_WIDTH-1:0]     i_data,
    output logic                      o_free,
    output logic [NCH-1:0]            o_driveNext_8,
    input  logic [NCH-1:0]            i_freeNext_8,
    output logic [NCH*DATA_WIDTH-1:0] o_data_8,
    output logic [NCH-1:0]            o_err_8,
    output logic                      o_ovf,
    output logic [CNT_WIDTH-1:0]      o_count
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [NCH-1:0]        busy_q, busy_d;
    logic [NCH-1:0]        err_q, err_d;
    logic                  ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [NCH-1:0]        drive_q, drive_d;
    logic                  free_q;
    logic [DATA_WIDTH-1:0] data_q [NCH];

    logic                  ev_in;
    logic [NCH-1:0]        ev_free;
    logic [DEST_W-1:0]     dest;
    logic                  avail;
    logic                  capture;
    logic                  dispatch;

    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_drive (
        .clk   (clk),
        .rstn  (rstn),
        .tog_i (i_drive),
        .ev_o  (ev_in)
    );

    for (genvar k = 0; k < NCH; k++) begin : g_free_sync
        toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_free (
            .clk   (clk),
            .rstn  (rstn),
            .tog_i (i_freeNext_8[k]),
            .ev_o  (ev_free[k])
        );
    end

    // A same-cycle free makes the head token's channel available immediately.
    assign dest  = get_dest(MAX_DW'(hold_q), DATA_WIDTH);
    assign avail = ~busy_q[dest] | ev_free[dest];

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: accept a token in IDLE, leave DISPATCH once its channel is available.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:     if (ev_in) state_d = DISPATCH;
            DISPATCH: if (avail) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FSM outputs: capture strobe in IDLE, dispatch strobe in DISPATCH.
    always_comb begin
        capture  = (state_q == IDLE) && ev_in;
        dispatch = (state_q == DISPATCH) && avail;
    end

    // Per-channel busy/error/toggle updates; frees apply before a same-cycle re-dispatch.
    always_comb begin
        busy_d  = busy_q & ~ev_free;
        err_d   = err_q | (ev_free & ~busy_q);
        drive_d = drive_q;
        ovf_d   = ovf_q | ((state_q == DISPATCH) && ev_in);
        if (dispatch) begin
            busy_d[dest]  = 1'b1;
            drive_d[dest] = ~drive_q[dest];
        end
    end

    // Token buffer, status registers and output toggles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_q  <= '0;
            busy_q  <= '0;
            err_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            drive_q <= '0;
            free_q  <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            drive_q <= drive_d;
            if (capture) begin
                hold_q <= i_data;
            end
            if (dispatch) begin
                free_q  <= ~free_q;
                count_q <= count_q + CNT_WIDTH'(1);
            end
        end
    end

    // Per-channel data registers; a slice only changes on a dispatch to its channel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: these registers drive outputs that must read 0 in reset, so they are reset too.
            for (int k = 0; k < NCH; k++) begin
                data_q[k] <= '0;
            end
        end else if (dispatch) begin
            data_q[dest] <= hold_q;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_data_out
        assign o_data_8[k*DATA_WIDTH +: DATA_WIDTH] = data_q[k];
    end

    assign o_free        = free_q;
    assign o_driveNext_8 = drive_q;
    assign o_err_8       = err_q;
    assign o_ovf         = ovf_q;
    assign o_count       = count_q;

endmodule

// File: tb/tb_sync_split8_retire.sv
// Scoreboard bench for sync_split8_retire: the stimulus thread pushes the
// expected dispatch of each token; a monitor pops and compares on every
// o_driveNext_8 transition.
module tb_sync_split8_retire;

    localparam int DW = 12;

    logic          clk;
    logic          rstn;
    logic          i_drive;
    logic [DW-1:0] i_data;
    logic          o_free;
    logic [7:0]    o_driveNext_8;
    logic [7:0]    i_freeNext_8;
    logic [8*DW-1:0] o_data_8;
    logic [7:0]    o_err_8;
    logic          o_ovf;
    logic [15:0]   o_count;

    sync_split8_retire #(
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (2),
        .CNT_WIDTH   (16)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_drive       (i_drive),
        .i_data        (i_data),
        .o_free        (o_free),
        .o_driveNext_8 (o_driveNext_8),
        .i_freeNext_8  (i_freeNext_8),
        .o_data_8      (o_data_8),
        .o_err_8       (o_err_8),
        .o_ovf         (o_ovf),
        .o_count       (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    ch;
        logic [DW-1:0] data;
        logic [15:0]   cnt;
    } exp_t;

    exp_t        exp_q [$];
    logic [15:0] exp_count;
    int          n_pass;
    int          n_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Issue one token at a falling edge and record the dispatch it must cause.
    task automatic issue(input logic [DW-1:0] d);
        exp_t e;
        @(negedge clk);
        exp_count = exp_count + 16'd1;
        e.ch   = d[DW-1 -: 3];
        e.data = d;
        e.cnt  = exp_count;
        exp_q.push_back(e);
        i_data  = d;
        i_drive = ~i_drive;
    endtask

    // Count rising edges until any request bit changes; -1 on timeout.
    task automatic wait_drive(output int n);
        logic [7:0] start;
        start = o_driveNext_8;
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (o_driveNext_8 != start) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn         = 1'b0;
        i_drive      = 1'b0;
        i_freeNext_8 = 8'h00;
        i_data       = '0;
        exp_q.delete();
        exp_count    = 16'd0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Monitor: every request transition must match the head of the scoreboard.
    logic [7:0] mon_drive;
    logic       mon_free;
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            mon_drive = 8'h00;
            mon_free  = 1'b0;
        end else begin
            if (o_driveNext_8 != mon_drive) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_dispatch", {24'h0, o_driveNext_8}, {24'h0, mon_drive});
                end else begin
                    e = exp_q.pop_front();
                    check("dispatch_channel", {24'h0, o_driveNext_8 ^ mon_drive}, 32'h1 << e.ch);
                    check("dispatch_data", {20'h0, o_data_8[e.ch*DW +: DW]}, {20'h0, e.data});
                    check("dispatch_count", {16'h0, o_count}, {16'h0, e.cnt});
                    check("dispatch_free_toggle", {31'h0, o_free ^ mon_free}, 32'h1);
                end
            end
            mon_drive = o_driveNext_8;
            mon_free  = o_free;
        end
    end

    initial begin
        int   n;
        logic fr;
        rstn         = 1'b0;
        i_drive      = 1'b0;
        i_freeNext_8 = 8'h00;
        i_data       = '0;
        exp_count    = 16'd0;
        n_pass       = 0;
        n_total      = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_free", {31'h0, o_free}, 32'h0);
        check("rst_drive", {24'h0, o_driveNext_8}, 32'h0);
        check("rst_err", {24'h0, o_err_8}, 32'h0);
        check("rst_ovf", {31'h0, o_ovf}, 32'h0);
        check("rst_count", {16'h0, o_count}, 32'h0);
        check("rst_data", {31'h0, |o_data_8}, 32'h0);
        rstn = 1'b1;

        // Single token to channel 5
        issue(12'hA5C);
        wait_drive(n);
        check("single_latency", n, 4);
        check("single_drive", {24'h0, o_driveNext_8}, 32'h20);
        check("single_slice5", {20'h0, o_data_8[5*DW +: DW]}, 32'hA5C);
        check("single_count", {16'h0, o_count}, 32'd1);

        // Round-robin fill of all eight channels
        do_reset();
        for (int k = 0; k < 8; k++) begin
            logic [2:0] kk;
            kk = 3'(k);
            issue({kk, 9'h0F0 + 9'(k)});
            wait_drive(n);
            check("rr_latency", n, 4);
        end
        check("rr_drive", {24'h0, o_driveNext_8}, 32'hFF);
        check("rr_count", {16'h0, o_count}, 32'd8);
        check("rr_err", {24'h0, o_err_8}, 32'h0);
        // Free every channel in the same cycle
        @(negedge clk);
        i_freeNext_8 = ~i_freeNext_8;
        repeat (5) @(negedge clk);
        check("rr_free_all_err", {24'h0, o_err_8}, 32'h0);

        // Stall on a busy channel 3, released by its free
        issue(12'h711);
        wait_drive(n);
        check("stall_first_latency", n, 4);
        fr = o_free;
        issue(12'h722);
        repeat (10) @(negedge clk);
        check("stall_free_held", {31'h0, o_free}, {31'h0, fr});
        check("stall_slice3_held", {20'h0, o_data_8[3*DW +: DW]}, 32'h711);
        i_freeNext_8[3] = ~i_freeNext_8[3];
        wait_drive(n);
        check("stall_release_latency", n, 3);
        check("stall_slice3_new", {20'h0, o_data_8[3*DW +: DW]}, 32'h722);

        // Free of channel 2 lands in the same cycle as a dest-2 dispatch
        issue(12'h4A0);
        wait_drive(n);
        check("same_first_latency", n, 4);
        issue(12'h4B1);
        @(negedge clk);
        i_freeNext_8[2] = ~i_freeNext_8[2];
        wait_drive(n);
        check("same_cycle_latency", n, 3);
        check("same_cycle_err", {24'h0, o_err_8}, 32'h0);
        // Channel 2 must still be busy, so this free is legal
        @(negedge clk);
        i_freeNext_8[2] = ~i_freeNext_8[2];
        repeat (6) @(negedge clk);
        check("same_cycle_busy_kept", {24'h0, o_err_8}, 32'h0);

        // Protocol errors: stray free, then a double drive
        do_reset();
        @(negedge clk);
        i_freeNext_8[6] = ~i_freeNext_8[6];
        repeat (6) @(negedge clk);
        check("err_stray_free", {24'h0, o_err_8}, 32'h40);
        check("err_no_ovf_yet", {31'h0, o_ovf}, 32'h0);
        issue(12'h2AB);
        @(negedge clk);
        i_drive = ~i_drive;
        repeat (10) @(negedge clk);
        check("ovf_flag", {31'h0, o_ovf}, 32'h1);
        check("ovf_count", {16'h0, o_count}, 32'd1);
        check("ovf_drive", {24'h0, o_driveNext_8}, 32'h02);

        // Reset while a token is stalled and busy = 8'h11
        do_reset();
        issue(12'h0A1);
        wait_drive(n);
        issue(12'h8B2);
        wait_drive(n);
        issue(12'h0C3);
        repeat (8) @(negedge clk);
        check("midop_pre_count", {16'h0, o_count}, 32'd2);
        check("midop_pre_drive", {24'h0, o_driveNext_8}, 32'h11);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("midop_async_drive", {24'h0, o_driveNext_8}, 32'h0);
        check("midop_async_count", {16'h0, o_count}, 32'h0);
        check("midop_async_data", {31'h0, |o_data_8}, 32'h0);
        check("midop_async_flags", {22'h0, o_err_8, o_ovf, o_free}, 32'h0);
        do_reset();
        issue(12'hE7F);
        wait_drive(n);
        check("midop_after_latency", n, 4);
        check("midop_after_count", {16'h0, o_count}, 32'd1);
        check("midop_after_slice7", {20'h0, o_data_8[7*DW +: DW]}, 32'hE7F);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
